multicycle_control_unit: RTL and testbench

Parametrised multi-cycle control unit for the 0xcHa0s CPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It handshakes with memory (`mem_req`/`mem_ready`) and with a multi-cycle ALU (`alu_start`/`alu_done`). It drives all datapath enables and reports halt and fault status. It sits between the instruction register/decoder and the register file, ALU and memory interface.

---
 rtl/cu_pkg.sv | 36 +++
 rtl/cu_wait_timer.sv | 39 +++
 rtl/multicycle_control_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode classes,
// FSM state encoding, pc_src selections, fault codes and fixed ALU ops.
package cu_pkg;

  // Opcode classes; any opcode above OP_MUL is illegal.
  localparam int unsigned OP_ALU   = 0;
  localparam int unsigned OP_LOAD  = 1;
  localparam int unsigned OP_STORE = 2;
  localparam int unsigned OP_BEQ   = 3;
  localparam int unsigned OP_JMP   = 4;
  localparam int unsigned OP_HALT  = 5;
  localparam int unsigned OP_MUL   = 6;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEMW,
    S_WB,
    S_HALT,
    S_FAULT
  } state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] FC_NONE        = 2'd0;
  localparam logic [1:0] FC_ILLEGAL     = 2'd1;
  localparam logic [1:0] FC_MEM_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_ALU_TIMEOUT = 2'd3;

  localparam int unsigned ALU_ADD = 0;
  localparam int unsigned ALU_SUB = 1;

endpackage

// File: rtl/cu_wait_timer.sv
// Wait counter for the handshake timeouts.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : clear the count (has priority over en)
//   en         : awaited signal is still low this cycle
//   timeout    : count has reached TIMEOUT and the signal is still low
module cu_wait_timer #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic timeout
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT so a long stall never wraps back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = en && (cnt_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEMW/WB, handshakes
// with memory (mem_req/mem_ready) and the multi-cycle ALU (alu_start/alu_done),
// and drives the datapath enables combinationally from the current state.
//   clk, rst_n          : clock, synchronous active-low reset
//   opcode, funct       : instruction fields, sampled in DECODE
//   zero                : ALU zero flag, used by BEQ in EXEC
//   mem_ready, alu_done : handshake completions
//   pc_write, pc_src    : PC load enable and source (seq/branch/jump)
//   ir_write            : IR load enable
//   mem_req, mem_we     : memory request / write
//   reg_write, wb_sel   : register write enable, write-back source
//   alu_op, alu_start   : ALU operation, multi-cycle ALU start pulse
//   halted, fault       : status, fault_code gives the fault cause
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int unsigned OPCODE_W = 6,
  parameter int unsigned FUNCT_W  = 4,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic                zero,
  input  logic                mem_ready,
  input  logic                alu_done,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                ir_write,
  output logic                mem_req,
  output logic                mem_we,
  output logic                reg_write,
  output logic                wb_sel,
  output logic [FUNCT_W-1:0]  alu_op,
  output logic                alu_start,
  output logic                halted,
  output logic                fault,
  output logic [1:0]          fault_code
);

  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] opc_q, opc_d;
  logic [FUNCT_W-1:0]  funct_q, funct_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic                mul_busy_q, mul_busy_d;

  logic is_mul;
  logic wait_mem;
  logic wait_alu;
  logic wait_en;
  logic wait_clr;
  logic wait_timeout;

  assign is_mul   = (opc_q == OPCODE_W'(OP_MUL));
  assign wait_mem = (state_q == S_FETCH) || (state_q == S_MEMW);
  assign wait_alu = (state_q == S_EXEC) && is_mul;
  assign wait_en  = (wait_mem && !mem_ready) || (wait_alu && !alu_done);
  // Clearing on every state change covers entry into each waiting state,
  // including MEMW -> FETCH where both ends are waits.
  assign wait_clr = (state_d != state_q);

  cu_wait_timer #(
    .TIMEOUT(TIMEOUT),
    .CNT_W  (CNT_W)
  ) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (wait_clr),
    .en     (wait_en),
    .timeout(wait_timeout)
  );

  // State and latched-instruction registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      opc_q        <= '0;
      funct_q      <= '0;
      fault_code_q <= FC_NONE;
      mul_busy_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      opc_q        <= opc_d;
      funct_q      <= funct_d;
      fault_code_q <= fault_code_d;
      mul_busy_q   <= mul_busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    opc_d        = opc_q;
    funct_d      = funct_q;
    fault_code_d = fault_code_q;

    unique case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (wait_timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_MEM_TIMEOUT;
        end
      end

      S_DECODE: begin
        opc_d   = opcode;
        funct_d = funct;
        if (opcode == OPCODE_W'(OP_HALT)) begin
          state_d = S_HALT;
        end else if (opcode > OPCODE_W'(OP_MUL)) begin
          state_d      = S_FAULT;
          fault_code_d = FC_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (opc_q)
          OPCODE_W'(OP_ALU):                     state_d = S_WB;
          OPCODE_W'(OP_LOAD), OPCODE_W'(OP_STORE): state_d = S_MEMW;
          OPCODE_W'(OP_BEQ), OPCODE_W'(OP_JMP):    state_d = S_FETCH;
          OPCODE_W'(OP_MUL): begin
            if (alu_done) begin
              state_d = S_WB;
            end else if (wait_timeout) begin
              state_d      = S_FAULT;
              fault_code_d = FC_ALU_TIMEOUT;
            end
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEMW: begin
        if (mem_ready) begin
          state_d = (opc_q == OPCODE_W'(OP_LOAD)) ? S_WB : S_FETCH;
        end else if (wait_timeout) begin
          state_d      = S_FAULT;
          fault_code_d = FC_MEM_TIMEOUT;
        end
      end

      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FETCH;
    endcase
  end

  // alu_start fires only while this flag is low, i.e. on the first MUL EXEC cycle.
  assign mul_busy_d = wait_alu && (state_d == S_EXEC);

  // Output decode.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 1'b0;
    alu_op     = '0;
    alu_start  = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    fault_code = FC_NONE;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_SEQ;
        end
      end

      S_EXEC: begin
        case (opc_q)
          OPCODE_W'(OP_ALU):                     alu_op = funct_q;
          OPCODE_W'(OP_LOAD), OPCODE_W'(OP_STORE): alu_op = FUNCT_W'(ALU_ADD);
          OPCODE_W'(OP_BEQ): begin
            alu_op = FUNCT_W'(ALU_SUB);
            if (zero) begin
              pc_write = 1'b1;
              pc_src   = PC_SRC_BRANCH;
            end
          end
          OPCODE_W'(OP_JMP): begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
          OPCODE_W'(OP_MUL): alu_start = !mul_busy_q;
          default: ;
        endcase
      end

      S_MEMW: begin
        mem_req = 1'b1;
        mem_we  = (opc_q == OPCODE_W'(OP_STORE));
      end

      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = (opc_q == OPCODE_W'(OP_LOAD));
      end

      S_HALT: halted = 1'b1;

      S_FAULT: begin
        fault      = 1'b1;
        fault_code = fault_code_q;
      end

      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit. Two instances share all inputs: one at
// TIMEOUT=16 and one at TIMEOUT=4 for the timeout scenarios. Each cycle's
// expected output vector is pushed to a scoreboard when the inputs are driven
// and popped when the outputs are sampled mid-cycle.
module tb_multicycle_control_unit;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  // Expected-vector bit fields, ordered as in obs below.
  localparam logic [16:0] B_PCW  = 17'h10000;
  localparam logic [16:0] PCS1   = 17'h04000;
  localparam logic [16:0] PCS2   = 17'h08000;
  localparam logic [16:0] B_IRW  = 17'h02000;
  localparam logic [16:0] B_MREQ = 17'h01000;
  localparam logic [16:0] B_MWE  = 17'h00800;
  localparam logic [16:0] B_RW   = 17'h00400;
  localparam logic [16:0] B_WBS  = 17'h00200;
  localparam logic [16:0] B_AST  = 17'h00010;
  localparam logic [16:0] B_HLT  = 17'h00008;
  localparam logic [16:0] B_FLT  = 17'h00004;
  localparam logic [16:0] E0     = 17'h00000;
  localparam logic [16:0] FHIT   = B_PCW | B_IRW | B_MREQ;

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [3:0]  fn;
    logic        z;
    logic        mr;
    logic        ad;
    logic        cm;
    logic [16:0] e;
    logic        c4;
    logic [16:0] e4;
  } step_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [3:0] funct = '0;
  logic zero = 1'b0, mem_ready = 1'b0, alu_done = 1'b0;

  logic pc_write, ir_write, mem_req, mem_we, reg_write, wb_sel, alu_start, halted, fault;
  logic [1:0] pc_src, fault_code;
  logic [3:0] alu_op;
  logic pc_write_4, ir_write_4, mem_req_4, mem_we_4, reg_write_4, wb_sel_4, alu_start_4;
  logic halted_4, fault_4;
  logic [1:0] pc_src_4, fault_code_4;
  logic [3:0] alu_op_4;

  logic [16:0] obs, obs4;
  int unsigned checks = 0;
  int unsigned errors = 0;
  step_t sb[$];

  always #5 clk = ~clk;

  multicycle_control_unit #(
    .OPCODE_W(6), .FUNCT_W(4), .TIMEOUT(16), .CNT_W(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_done(alu_done), .pc_write(pc_write), .pc_src(pc_src),
    .ir_write(ir_write), .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write),
    .wb_sel(wb_sel), .alu_op(alu_op), .alu_start(alu_start), .halted(halted),
    .fault(fault), .fault_code(fault_code)
  );

  multicycle_control_unit #(
    .OPCODE_W(6), .FUNCT_W(4), .TIMEOUT(4), .CNT_W(5)
  ) dut_t4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alu_done(alu_done), .pc_write(pc_write_4), .pc_src(pc_src_4),
    .ir_write(ir_write_4), .mem_req(mem_req_4), .mem_we(mem_we_4), .reg_write(reg_write_4),
    .wb_sel(wb_sel_4), .alu_op(alu_op_4), .alu_start(alu_start_4), .halted(halted_4),
    .fault(fault_4), .fault_code(fault_code_4)
  );

  assign obs  = {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, wb_sel,
                 alu_op, alu_start, halted, fault, fault_code};
  assign obs4 = {pc_write_4, pc_src_4, ir_write_4, mem_req_4, mem_we_4, reg_write_4, wb_sel_4,
                 alu_op_4, alu_start_4, halted_4, fault_4, fault_code_4};

  function automatic logic [16:0] aop(input logic [3:0] a);
    return {8'b0, a, 5'b0};
  endfunction

  function automatic logic [16:0] fcode(input logic [1:0] c);
    return B_FLT | {15'b0, c};
  endfunction

  function automatic step_t st(input logic r, input logic [5:0] op, input logic [3:0] fn,
                               input logic z, input logic mr, input logic ad,
                               input logic cm, input logic [16:0] e,
                               input logic c4, input logic [16:0] e4);
    step_t s;
    s.r = r; s.op = op; s.fn = fn; s.z = z; s.mr = mr; s.ad = ad;
    s.cm = cm; s.e = e; s.c4 = c4; s.e4 = e4;
    return s;
  endfunction

  // Same expectation for both instances.
  function automatic step_t both(input logic r, input logic [5:0] op, input logic [3:0] fn,
                                 input logic z, input logic mr, input logic ad,
                                 input logic [16:0] e);
    return st(r, op, fn, z, mr, ad, H, e, H, e);
  endfunction

  task automatic apply(input step_t s);
    rst_n = s.r; opcode = s.op; funct = s.fn; zero = s.z; mem_ready = s.mr; alu_done = s.ad;
  endtask

  // Leaves rst_n low across one edge; the first plan step's edge resets again
  // and releases it, so plan step 0 is the first post-reset cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; alu_done = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL reset[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL reset_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  task automatic test_alu();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd0, 4'd5, L, H, L, E0));
    plan.push_back(both(H, 6'd9, 4'd0, L, H, L, aop(4'd5)));   // IR fields ignored outside DECODE
    plan.push_back(both(H, 6'd9, 4'd0, L, H, L, B_RW));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL alu[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL alu_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  task automatic test_load_store();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd1, 4'd7, L, L, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, E0));             // EXEC: ADD, mem_ready ignored
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, B_RW | B_WBS));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd2, 4'd0, L, L, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ | B_MWE));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, B_MREQ | B_MWE));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL ldst[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL ldst_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  task automatic test_branch_jump();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd3, 4'd0, L, H, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, H, H, L, B_PCW | PCS1 | aop(4'd1)));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd3, 4'd0, L, H, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, aop(4'd1)));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd4, 4'd0, L, H, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, H, H, L, B_PCW | PCS2));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL branch[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL branch_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  // alu_done arrives in the 7th EXEC cycle; only the TIMEOUT=16 instance is checked.
  task automatic test_mul();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(st(H, 6'd0, 4'd0, L, H, H, H, FHIT, L, E0));   // alu_done ignored in FETCH
    plan.push_back(st(H, 6'd6, 4'd3, L, L, L, H, E0, L, E0));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, B_AST, L, E0));
    for (int k = 0; k < 5; k++) plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, E0, L, E0));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, H, H, E0, L, E0));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, B_RW, L, E0));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, B_MREQ, L, E0));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL mul[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL mul_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  // TIMEOUT=4: counter 0..4 over EXEC cycles 1..5, fault visible in the 6th.
  task automatic test_mul_timeout();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd6, 4'd2, L, L, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_AST));
    for (int k = 0; k < 4; k++) plan.push_back(both(H, 6'd0, 4'd0, L, L, L, E0));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, E0, H, fcode(2'd3)));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, E0, H, fcode(2'd3)));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL multo[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL multo_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  // mem_ready rising at the exact timeout cycle wins; later a true timeout.
  task automatic test_mem_timeout();
    step_t plan[$];
    step_t cur;
    do_reset();
    for (int k = 0; k < 4; k++) plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd0, 4'd2, L, L, L, E0));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, aop(4'd2)));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_RW));
    for (int k = 0; k < 5; k++) plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(st(H, 6'd0, 4'd0, L, H, L, H, FHIT, H, fcode(2'd2)));
    plan.push_back(st(H, 6'd0, 4'd0, L, H, L, H, E0, H, fcode(2'd2)));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL memto[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL memto_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  task automatic test_illegal();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd9, 4'd0, L, H, L, E0));
    for (int k = 0; k < 10; k++)
      plan.push_back(both(H, 6'd0, 4'd0, L, k[0], H, fcode(2'd1)));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL illegal[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL illegal_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  task automatic test_halt();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    plan.push_back(both(H, 6'd5, 4'd0, L, H, L, E0));
    for (int k = 0; k < 6; k++) plan.push_back(both(H, 6'd0, 4'd0, H, H, H, B_HLT));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL halt[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL halt_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  // Reset during a FETCH wait must clear the wait counter (TIMEOUT=4 instance
  // would otherwise fault in cycle 6), and reset from FAULT restarts cleanly.
  task automatic test_reset_midwait();
    step_t plan[$];
    step_t cur;
    do_reset();
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(L, 6'd0, 4'd0, L, L, L, B_MREQ));
    for (int k = 0; k < 5; k++) plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(st(H, 6'd0, 4'd0, L, L, L, H, B_MREQ, H, fcode(2'd2)));
    plan.push_back(st(H, 6'd0, 4'd0, L, H, L, H, FHIT, H, fcode(2'd2)));
    plan.push_back(st(L, 6'd0, 4'd0, L, L, L, H, E0, H, fcode(2'd2)));
    plan.push_back(both(H, 6'd0, 4'd0, L, L, L, B_MREQ));
    plan.push_back(both(H, 6'd0, 4'd0, L, H, L, FHIT));
    foreach (plan[i]) begin
      @(posedge clk); #1; apply(plan[i]); sb.push_back(plan[i]);
      #3; cur = sb.pop_front();
      if (cur.cm) begin checks++; if (obs !== cur.e) begin errors++;
        $display("FAIL rstwait[%0d]: got %h expected %h", i, obs, cur.e); end end
      if (cur.c4) begin checks++; if (obs4 !== cur.e4) begin errors++;
        $display("FAIL rstwait_t4[%0d]: got %h expected %h", i, obs4, cur.e4); end end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch_jump();
    test_mul();
    test_mul_timeout();
    test_mem_timeout();
    test_illegal();
    test_halt();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
